// File: rtl/object_slot_allocator_pkg.sv
// Shared definitions for the object slot allocator: FSM encodings and the
// default parameter values used by the top level.
package object_slot_allocator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_DROP = 2'd2
  } alloc_state_t;

  localparam int DEFAULT_OBJECT_AMOUNT = 5;
  localparam int DEFAULT_ACK_TIMEOUT   = 15;

endpackage

// File: rtl/object_slot_allocator_lowest_free_encoder.sv
// Priority encoder: returns the lowest set index of a free-slot map, plus a
// flag for the case where no slot is free.
module lowest_free_encoder #(
  parameter int N = 5
) (
  input  logic [N-1:0] free_map,
  output logic [3:0]   free_idx,
  output logic         none_free
);

  always_comb begin
    free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_map[i]) free_idx = 4'(i);
    end
    none_free = ~|free_map;
  end

endmodule

// File: rtl/object_slot_allocator.sv
// Hands spawn requests from the object ROM loader to the lowest free object
// slot, waits for that slot's ack, and tracks slot occupancy.
//   state     | meaning
//   IDLE      | waiting for spawn_req; allocate or reject
//   LOAD      | strobing slot_load at active_slot, waiting for ack or timeout
//   WAIT_DROP | request answered; waiting for the loader to drop spawn_req
module object_slot_allocator
  import object_slot_allocator_pkg::*;
#(
  parameter int OBJECT_AMOUNT = DEFAULT_OBJECT_AMOUNT,
  parameter int ACK_TIMEOUT   = DEFAULT_ACK_TIMEOUT
) (
  input  logic                     clk_calculation,
  input  logic                     reset,
  input  logic                     spawn_req,
  input  logic [OBJECT_AMOUNT-1:0] slot_loaded,
  input  logic [OBJECT_AMOUNT-1:0] slot_free,
  output logic [OBJECT_AMOUNT-1:0] slot_load,
  output logic [OBJECT_AMOUNT-1:0] slot_busy,
  output logic [3:0]               active_slot,
  output logic [3:0]               busy_count,
  output logic                     all_busy,
  output logic                     spawn_done,
  output logic                     spawn_reject
);

  alloc_state_t             state, state_n;
  logic [3:0]               active_n;
  logic [7:0]               timer, timer_n;
  logic [OBJECT_AMOUNT-1:0] busy_n;
  logic                     done_n, reject_n;
  logic [OBJECT_AMOUNT-1:0] active_onehot;
  logic [OBJECT_AMOUNT-1:0] set_vec, free_vec;
  logic [3:0]               free_idx;
  logic                     none_free;

  lowest_free_encoder #(.N(OBJECT_AMOUNT)) u_lowest_free (
    .free_map  (~slot_busy),
    .free_idx  (free_idx),
    .none_free (none_free)
  );

  always_comb begin
    busy_count = '0;
    for (int i = 0; i < OBJECT_AMOUNT; i++) begin
      busy_count = busy_count + 4'(slot_busy[i]);
      active_onehot[i] = (active_slot == 4'(i));
    end
    all_busy = &slot_busy;
  end

  always_ff @(posedge clk_calculation or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      active_slot  <= '0;
      timer        <= '0;
      slot_busy    <= '0;
      spawn_done   <= 1'b0;
      spawn_reject <= 1'b0;
    end else begin
      state        <= state_n;
      active_slot  <= active_n;
      timer        <= timer_n;
      slot_busy    <= busy_n;
      spawn_done   <= done_n;
      spawn_reject <= reject_n;
    end
  end

  always_comb begin
    state_n   = state;
    active_n  = active_slot;
    timer_n   = timer;
    done_n    = 1'b0;
    reject_n  = 1'b0;
    set_vec   = '0;
    free_vec  = slot_free;
    slot_load = '0;

    case (state)
      ST_IDLE: begin
        if (spawn_req) begin
          if (all_busy) begin
            reject_n = 1'b1;
            state_n  = ST_WAIT_DROP;
          end else begin
            active_n = free_idx;
            timer_n  = '0;
            state_n  = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        slot_load = active_onehot;
        // A release of the slot being loaded is stale; the new object owns it.
        free_vec  = slot_free & ~active_onehot;
        if (!spawn_req) begin
          state_n = ST_IDLE;
        end else if (|(slot_loaded & active_onehot)) begin
          set_vec = active_onehot;
          done_n  = 1'b1;
          state_n = ST_WAIT_DROP;
        end else if (timer + 8'd1 == 8'(ACK_TIMEOUT)) begin
          reject_n = 1'b1;
          state_n  = ST_WAIT_DROP;
        end else begin
          timer_n = timer + 8'd1;
        end
      end
      ST_WAIT_DROP: begin
        if (!spawn_req) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n = (slot_busy & ~free_vec) | set_vec;
  end

  logic unused_none_free;
  assign unused_none_free = none_free;

endmodule

// File: tb/tb_object_slot_allocator.sv
// Directed bench for object_slot_allocator (5 slots, ack timeout 15) with
// hand-computed expectations checked by immediate assertions.
module tb_object_slot_allocator;

  logic       clk_calculation;
  logic       reset;
  logic       spawn_req;
  logic [4:0] slot_loaded;
  logic [4:0] slot_free;
  logic [4:0] slot_load;
  logic [4:0] slot_busy;
  logic [3:0] active_slot;
  logic [3:0] busy_count;
  logic       all_busy;
  logic       spawn_done;
  logic       spawn_reject;

  int vectors = 0;
  int miscompares = 0;

  object_slot_allocator #(.OBJECT_AMOUNT(5), .ACK_TIMEOUT(15)) dut (
    .clk_calculation (clk_calculation),
    .reset           (reset),
    .spawn_req       (spawn_req),
    .slot_loaded     (slot_loaded),
    .slot_free       (slot_free),
    .slot_load       (slot_load),
    .slot_busy       (slot_busy),
    .active_slot     (active_slot),
    .busy_count      (busy_count),
    .all_busy        (all_busy),
    .spawn_done      (spawn_done),
    .spawn_reject    (spawn_reject)
  );

  initial clk_calculation = 1'b0;
  always #5 clk_calculation = ~clk_calculation;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_calculation);
    #1;
  endtask

  // Full handshake on the slot the allocator is expected to pick.
  task automatic do_spawn(input int idx);
    logic [4:0] oh;
    oh = 5'd1 << idx;
    spawn_req = 1'b1;
    tick();
    check("spawn_active_slot", 32'(active_slot), 32'(idx));
    check("spawn_slot_load", 32'(slot_load), 32'(oh));
    slot_loaded = oh;
    tick();
    check("spawn_done_pulse", 32'(spawn_done), 32'd1);
    check("spawn_load_dropped", 32'(slot_load), 32'd0);
    slot_loaded = '0;
    spawn_req = 1'b0;
    tick();
    check("spawn_done_cleared", 32'(spawn_done), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    spawn_req = 1'b0;
    slot_loaded = '0;
    slot_free = '0;
    #1;
    check("rst_slot_busy", 32'(slot_busy), 32'd0);
    check("rst_slot_load", 32'(slot_load), 32'd0);
    check("rst_active_slot", 32'(active_slot), 32'd0);
    check("rst_done", 32'(spawn_done), 32'd0);
    check("rst_reject", 32'(spawn_reject), 32'd0);
    check("rst_busy_count", 32'(busy_count), 32'd0);
    check("rst_all_busy", 32'(all_busy), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // First spawn into slot 0, ack two cycles after the request
    spawn_req = 1'b1;
    tick();
    check("a_slot_load", 32'(slot_load), 32'b00001);
    tick();
    check("a_still_loading", 32'(slot_load), 32'b00001);
    slot_loaded = 5'b00001;
    tick();
    check("a_done", 32'(spawn_done), 32'd1);
    check("a_slot_busy", 32'(slot_busy), 32'b00001);
    check("a_busy_count", 32'(busy_count), 32'd1);
    slot_loaded = '0;
    spawn_req = 1'b0;
    tick();
    check("a_done_one_cycle", 32'(spawn_done), 32'd0);

    // Build 01111, free slot 2 from IDLE, then refill it
    do_spawn(1);
    do_spawn(2);
    do_spawn(3);
    check("b_busy_full4", 32'(slot_busy), 32'b01111);
    slot_free = 5'b00100;
    tick();
    slot_free = '0;
    check("b_busy_01011", 32'(slot_busy), 32'b01011);
    check("b_count_3", 32'(busy_count), 32'd3);
    do_spawn(2);
    check("b_busy_01111", 32'(slot_busy), 32'b01111);

    // All busy: single reject, nothing more while request is held
    do_spawn(4);
    check("c_busy_all", 32'(slot_busy), 32'b11111);
    check("c_all_busy", 32'(all_busy), 32'd1);
    check("c_count_5", 32'(busy_count), 32'd5);
    spawn_req = 1'b1;
    tick();
    check("c_reject", 32'(spawn_reject), 32'd1);
    check("c_no_load", 32'(slot_load), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("c_hold_reject", 32'(spawn_reject), 32'd0);
      check("c_hold_load", 32'(slot_load), 32'd0);
      check("c_hold_done", 32'(spawn_done), 32'd0);
    end
    spawn_req = 1'b0;
    tick();

    // Ack timeout on slot 1
    slot_free = 5'b00010;
    tick();
    slot_free = '0;
    check("d_busy_11101", 32'(slot_busy), 32'b11101);
    spawn_req = 1'b1;
    tick();
    check("d_active_1", 32'(active_slot), 32'd1);
    check("d_slot_load", 32'(slot_load), 32'b00010);
    for (int i = 0; i < 14; i++) tick();
    check("d_pre_timeout_load", 32'(slot_load), 32'b00010);
    check("d_pre_timeout_reject", 32'(spawn_reject), 32'd0);
    tick();
    check("d_timeout_reject", 32'(spawn_reject), 32'd1);
    check("d_timeout_load", 32'(slot_load), 32'd0);
    check("d_timeout_busy", 32'(slot_busy), 32'b11101);
    tick();
    check("d_wait_no_alloc", 32'(slot_load), 32'd0);
    check("d_wait_no_reject", 32'(spawn_reject), 32'd0);
    spawn_req = 1'b0;
    tick();

    // Set wins over a same-cycle free on the loading slot; other free applies
    do_spawn(1);
    slot_free = 5'b01000;
    tick();
    slot_free = '0;
    check("e_busy_10111", 32'(slot_busy), 32'b10111);
    spawn_req = 1'b1;
    tick();
    check("e_slot_load", 32'(slot_load), 32'b01000);
    slot_free = 5'b01001;
    slot_loaded = 5'b01000;
    tick();
    slot_free = '0;
    slot_loaded = '0;
    check("e_busy_11110", 32'(slot_busy), 32'b11110);
    check("e_done", 32'(spawn_done), 32'd1);
    spawn_req = 1'b0;
    tick();

    // Reset pulse mid-LOAD
    spawn_req = 1'b1;
    tick();
    check("f_slot_load", 32'(slot_load), 32'b00001);
    #2;
    reset = 1'b1;
    #1;
    check("f_rst_load", 32'(slot_load), 32'd0);
    check("f_rst_busy", 32'(slot_busy), 32'd0);
    check("f_rst_done", 32'(spawn_done), 32'd0);
    check("f_rst_reject", 32'(spawn_reject), 32'd0);
    tick();
    check("f_rst_hold_done", 32'(spawn_done), 32'd0);
    check("f_rst_hold_reject", 32'(spawn_reject), 32'd0);
    spawn_req = 1'b0;
    reset = 1'b0;
    tick();
    do_spawn(0);
    check("f_restart_busy", 32'(slot_busy), 32'b00001);

    // Abort by dropping the request in LOAD
    spawn_req = 1'b1;
    tick();
    check("g_slot_load", 32'(slot_load), 32'b00010);
    spawn_req = 1'b0;
    tick();
    check("g_abort_load", 32'(slot_load), 32'd0);
    check("g_abort_done", 32'(spawn_done), 32'd0);
    check("g_abort_reject", 32'(spawn_reject), 32'd0);
    check("g_abort_busy", 32'(slot_busy), 32'b00001);
    spawn_req = 1'b1;
    tick();
    check("g_realloc_load", 32'(slot_load), 32'b00010);
    spawn_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/object_slot_allocator.md
OBJECT_SLOT_ALLOCATOR -- requirements
Module: object_slot_allocator

Interface
REQ-001 SHALL have parameter OBJECT_AMOUNT, default 5, number of object slots (range 1..15).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, max cycles in LOAD awaiting slot ack (range 1..255).
REQ-003 SHALL have port clk_calculation  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port spawn_req  input  1  level request from object ROM loader, held until spawn_done/spawn_reject seen.
REQ-006 SHALL have port slot_loaded  input  OBJECT_AMOUNT  per-slot ack: slot has latched the spawn data.
REQ-007 SHALL have port slot_free  input  OBJECT_AMOUNT  per-slot release (object destroyed or off-screen).
REQ-008 SHALL have port slot_load  output  OBJECT_AMOUNT  one-hot load strobe to the target slot.
REQ-009 SHALL have port slot_busy  output  OBJECT_AMOUNT  registered occupancy bitmap.
REQ-010 SHALL have port active_slot  output  4  index of slot currently targeted.
REQ-011 SHALL have port busy_count  output  4  population count of slot_busy.
REQ-012 SHALL have port all_busy  output  1  high when every slot_busy bit is set.
REQ-013 SHALL have port spawn_done  output  1  one-cycle pulse: spawn accepted and slot loaded.
REQ-014 SHALL have port spawn_reject  output  1  one-cycle pulse: no free slot or ack timeout.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, WAIT_DROP.
REQ-016 IDLE: spawn_req=1 and all_busy=0 SHALL latch lowest-index free slot into active_slot, clear timer, go LOAD.
REQ-017 IDLE: spawn_req=1 and all_busy=1 SHALL pulse spawn_reject next cycle and go WAIT_DROP.
REQ-018 LOAD: slot_load SHALL be one-hot at active_slot; zero in all other states.
REQ-019 LOAD: slot_loaded[active_slot]=1 SHALL set slot_busy[active_slot], pulse spawn_done next cycle, go WAIT_DROP.
REQ-020 LOAD: timer (8-bit, +1 per cycle) reaching ACK_TIMEOUT without ack SHALL pulse spawn_reject, leave slot_busy unchanged, go WAIT_DROP.
REQ-021 LOAD: spawn_req=0 SHALL abort to IDLE, no done/reject pulse, slot_busy unchanged.
REQ-022 WAIT_DROP: SHALL return to IDLE on first cycle spawn_req=0; no new allocation before then.
REQ-023 slot_loaded bits other than active_slot, or outside LOAD, SHALL be ignored.
REQ-024 slot_free[i]=1 SHALL clear slot_busy[i] at the next edge, in any state.
REQ-025 slot_free[active_slot] in LOAD SHALL be ignored; same-cycle set and clear on one slot: set wins.
REQ-026 Set of one slot and free of another in the same cycle SHALL both take effect.
REQ-027 Latency: spawn_req sampled at edge N in IDLE -> slot_load high from N; ack sampled at edge M -> spawn_done high for cycle after M.
REQ-028 busy_count and all_busy SHALL derive combinationally from registered slot_busy.

Reset
REQ-029 reset=1 SHALL immediately force: state IDLE, slot_busy=0, slot_load=0, active_slot=0, timer=0, spawn_done=0, spawn_reject=0.
REQ-030 reset asserted mid-LOAD SHALL drop slot_load without pulsing done/reject; allocator restarts in IDLE after release.

Structure
REQ-031 Shared package SHALL hold FSM state encodings, default OBJECT_AMOUNT, default ACK_TIMEOUT.
REQ-032 One sub-module lowest_free_encoder SHALL map ~slot_busy to lowest free index plus none_free flag.

Verification
REQ-033 Reset, spawn_req=1, slot_loaded[0] after 2 cycles -> slot_load=00001, spawn_done pulse, slot_busy=00001, busy_count=1.
REQ-034 slot_busy=01011, spawn_req -> active_slot=2, slot_load=00100; ack -> slot_busy=01111.
REQ-035 All 5 busy, spawn_req -> spawn_reject one cycle, no slot_load; hold req -> no further pulses until req drops.
REQ-036 LOAD on slot 1, no ack for 15 cycles -> spawn_reject, slot_busy[1]=0, state WAIT_DROP.
REQ-037 LOAD on slot 3 with slot_free[3] and slot_free[0] plus slot_loaded[3] same cycle -> slot_busy[3]=1, slot_busy[0]=0.
REQ-038 reset pulse mid-LOAD -> slot_load=0 immediately, slot_busy=0, no spawn_done/reject.
